// File: rtl/snake_pkg.sv
// Shared types and defaults for the Snake food placer: grid geometry,
// coordinate types and the placer state encoding.
package snake_pkg;

  localparam int GRID_W_DEF    = 40;
  localparam int GRID_H_DEF    = 30;
  localparam int X_BITS_DEF    = 6;
  localparam int Y_BITS_DEF    = 5;
  localparam int MAX_TRIES_DEF = 8;
  localparam int RND_BITS      = 15;

  typedef logic [X_BITS_DEF-1:0] coord_x_t;
  typedef logic [Y_BITS_DEF-1:0] coord_y_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    SCAN_Q = 3'd4,
    SCAN_W = 3'd5,
    SCAN_C = 3'd6
  } fp_state_t;

  // True when a candidate coordinate lies on the playfield.
  function automatic logic in_grid(input logic [15:0] x, input logic [15:0] y,
                                   input int unsigned w, input int unsigned h);
    return (32'(x) < w) && (32'(y) < h);
  endfunction

endpackage

// File: rtl/food_cand_gen.sv
// Candidate generator: salts the LFSR word with a free-running counter so a
// static rnd still yields a new candidate every cycle, and flags in-range ones.
module food_cand_gen
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int X_BITS = X_BITS_DEF,
  parameter int Y_BITS = Y_BITS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [RND_BITS-1:0] rnd,
  output logic [X_BITS-1:0]   cand_x,
  output logic [Y_BITS-1:0]   cand_y,
  output logic                cand_ok
);

  logic [RND_BITS-1:0] salt_q, salt_d;
  logic [RND_BITS-1:0] cand_s;

  always_comb begin
    salt_d  = salt_q + 15'd1;
    cand_s  = rnd ^ salt_q;
    cand_x  = cand_s[X_BITS-1:0];
    cand_y  = cand_s[X_BITS+Y_BITS-1:X_BITS];
    cand_ok = in_grid(16'(cand_x), 16'(cand_y), GRID_W, GRID_H);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      salt_q <= 15'd0;
    end else begin
      salt_q <= salt_d;
    end
  end

  // Bits above the coordinate fields play no part in placement.
  if (X_BITS + Y_BITS < RND_BITS) begin : g_hi
    logic unused_hi_s;
    assign unused_hi_s = ^cand_s[RND_BITS-1:X_BITS+Y_BITS];
  end

endmodule

// File: rtl/food_placer.sv
// Snake food placer: samples salted random cells against the occupancy memory
// and publishes the first free one. FOOD_SCAN_FALLBACK_EN adds a raster scan.
module food_placer
  import snake_pkg::*;
#(
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int X_BITS    = X_BITS_DEF,
  parameter int Y_BITS    = Y_BITS_DEF,
  parameter int MAX_TRIES = MAX_TRIES_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [RND_BITS-1:0] rnd,
  input  logic                place_req,
  output logic                query_en,
  output logic [X_BITS-1:0]   query_x,
  output logic [Y_BITS-1:0]   query_y,
  input  logic                occupied,
  output logic [X_BITS-1:0]   food_x,
  output logic [Y_BITS-1:0]   food_y,
  output logic                food_valid,
  output logic                busy,
  output logic                fail
);

  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

  fp_state_t            state_q, state_d, reject_st_s;
  logic [TRIES_W-1:0]   tries_q, tries_d, tries_inc_s;
  logic                 query_en_q, query_en_d;
  logic [X_BITS-1:0]    query_x_q, query_x_d, food_x_q, food_x_d, cand_x_s;
  logic [Y_BITS-1:0]    query_y_q, query_y_d, food_y_q, food_y_d, cand_y_s;
  logic                 food_valid_q, food_valid_d;
  logic                 busy_q, busy_d;
  logic                 cand_ok_s;
`ifdef FOOD_SCAN_FALLBACK_EN
  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(GRID_H - 1);
  logic [X_BITS-1:0]    scan_x_q, scan_x_d;
  logic [Y_BITS-1:0]    scan_y_q, scan_y_d;
  logic                 fail_q, fail_d;
`endif

  food_cand_gen #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_cand (
    .clock   (clock),
    .reset   (reset),
    .rnd     (rnd),
    .cand_x  (cand_x_s),
    .cand_y  (cand_y_s),
    .cand_ok (cand_ok_s)
  );

  // Saturating so the count stays meaningful when the limit is not acted on.
  always_comb begin
    if (tries_q == TRIES_MAX) begin
      tries_inc_s = tries_q;
    end else begin
      tries_inc_s = tries_q + TRIES_W'(1);
    end
`ifdef FOOD_SCAN_FALLBACK_EN
    reject_st_s = (tries_inc_s == TRIES_MAX) ? SCAN_Q : SAMPLE;
`else
    reject_st_s = SAMPLE;
`endif
  end

  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    query_en_d   = 1'b0;
    query_x_d    = query_x_q;
    query_y_d    = query_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    busy_d       = busy_q;
`ifdef FOOD_SCAN_FALLBACK_EN
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    fail_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (place_req) begin
          food_valid_d = 1'b0;
          busy_d       = 1'b1;
          tries_d      = '0;
          state_d      = SAMPLE;
`ifdef FOOD_SCAN_FALLBACK_EN
          scan_x_d     = '0;
          scan_y_d     = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SAMPLE: begin
        if (cand_ok_s) begin
          query_en_d = 1'b1;
          query_x_d  = cand_x_s;
          query_y_d  = cand_y_s;
          state_d    = WAIT;
        end else begin
          tries_d = tries_inc_s;
          state_d = reject_st_s;
        end
      end
      WAIT: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (!occupied) begin
          food_x_d     = query_x_q;
          food_y_d     = query_y_q;
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          tries_d = tries_inc_s;
          state_d = reject_st_s;
        end
      end
`ifdef FOOD_SCAN_FALLBACK_EN
      SCAN_Q: begin
        query_en_d = 1'b1;
        query_x_d  = scan_x_q;
        query_y_d  = scan_y_q;
        state_d    = SCAN_W;
      end
      SCAN_W: begin
        state_d = SCAN_C;
      end
      SCAN_C: begin
        if (!occupied) begin
          food_x_d     = query_x_q;
          food_y_d     = query_y_q;
          food_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if ((scan_x_q == X_LAST) && (scan_y_q == Y_LAST)) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (scan_x_q == X_LAST) begin
          scan_x_d = '0;
          scan_y_d = scan_y_q + Y_BITS'(1);
          state_d  = SCAN_Q;
        end else begin
          scan_x_d = scan_x_q + X_BITS'(1);
          state_d  = SCAN_Q;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      tries_q      <= '0;
      query_en_q   <= 1'b0;
      query_x_q    <= '0;
      query_y_q    <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      fail_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      query_en_q   <= query_en_d;
      query_x_q    <= query_x_d;
      query_y_q    <= query_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      busy_q       <= busy_d;
`ifdef FOOD_SCAN_FALLBACK_EN
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      fail_q       <= fail_d;
`endif
    end
  end

  assign query_en   = query_en_q;
  assign query_x    = query_x_q;
  assign query_y    = query_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign busy       = busy_q;
`ifdef FOOD_SCAN_FALLBACK_EN
  assign fail       = fail_q;
`else
  assign fail       = 1'b0;
`endif

endmodule

// File: doc/food_placer.md
# food_placer

Chooses a free grid cell for the next food item in the Snake game. The block sits directly downstream of the 15-bit LFSR random source and consumes its `rnd` word. Each candidate is checked against the snake-body occupancy memory, and the block publishes the food coordinate to the game controller and renderer. It is triggered on game start and whenever food is eaten.

## Interface
Parameters:
- `GRID_W`, 40: playfield width in cells.
- `GRID_H`, 30: playfield height in cells.
- `X_BITS`, 6: x coordinate width. Requires `X_BITS+Y_BITS <= 15`.
- `Y_BITS`, 5: y coordinate width.
- `MAX_TRIES`, 8: random attempts before the fallback scan (see Configuration).

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high; clears all state on the clock edge.
- `rnd` in 15: random word from the LFSR; may hold its value for many cycles.
- `place_req` in 1: one-cycle request for new food; ignored while `busy`.
- `query_en` out 1: occupancy read strobe (registered).
- `query_x` out X_BITS: occupancy read x (registered).
- `query_y` out Y_BITS: occupancy read y (registered).
- `occupied` in 1: occupancy data, valid the cycle after `query_en` is high.
- `food_x` out X_BITS: current food x.
- `food_y` out Y_BITS: current food y.
- `food_valid` out 1: food coordinate valid.
- `busy` out 1: placement in progress.
- `fail` out 1: one-cycle pulse when no free cell exists.

## Operation
- Salt: 15-bit free-running counter, reset to 0, increments every clock.
- Candidate: `cand = rnd ^ salt`.
  - x = `cand[X_BITS-1:0]`.
  - y = `cand[X_BITS+Y_BITS-1:X_BITS]`.
  - The salt guarantees distinct candidates while `rnd` is static.
- IDLE:
  - Outputs hold.
  - On `place_req`: `food_valid`<=0, `busy`<=1, tries<=0, go to SAMPLE.
- SAMPLE:
  - If x>=GRID_W or y>=GRID_H: tries++, apply the limit rule, stay in SAMPLE.
  - Otherwise: register `query_en`=1 and `query_x/y`=candidate, go to WAIT.
- WAIT: `query_en` high for exactly this cycle, then go to CHECK.
- CHECK: sample `occupied`.
  - If 0: `food_x/y`<=query coordinates, `food_valid`<=1, `busy`<=0, go to IDLE.
  - If 1: tries++, apply the limit rule, go to SAMPLE.
- Limit rule: when tries reaches MAX_TRIES, go to SCAN_Q (macro defined only).
- SCAN_Q, SCAN_W, SCAN_C: raster scan from (0,0), x fastest.
  - Same query/wait/check cadence as the random path.
  - First free cell is published as food.
  - After (GRID_W-1, GRID_H-1) is found occupied: `fail` pulses 1, `busy`<=0, `food_valid` stays 0, go to IDLE.
- `place_req` is ignored while `busy`=1, including a request in the same cycle the current placement completes.
- Reset mid-operation aborts the placement. All outputs take their reset values and the state returns to IDLE.
- Reset values: `food_x/y`=0, `food_valid`=0, `busy`=0, `fail`=0, `query_en`=0, `query_x/y`=0, salt=0, tries=0.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- Cycle-by-cycle, with `place_req` high in cycle 0:
  - Cycle 1: `busy`=1, `food_valid`=0.
  - Best case: `query_en`=1 in cycle 2, `occupied` sampled in cycle 3, `food_valid`=1 and `busy`=0 in cycle 4.
- Per-candidate cost:
  - Out-of-range candidate: 1 cycle.
  - Occupied in-range candidate: 3 cycles.
  - Each scanned cell: 3 cycles.
- `query_en` is never high in two consecutive cycles.
- `fail` lasts exactly one cycle.

## Configuration
- Macro: `FOOD_SCAN_FALLBACK_EN`.
- Defined:
  - After MAX_TRIES rejected candidates (out-of-range or occupied), the block enters the deterministic raster scan.
  - Termination is guaranteed; the worst case is MAX_TRIES·3 + GRID_W·GRID_H·3 cycles.
  - `fail` is reachable.
- Undefined:
  - The scan states are not compiled; the tries counter is still counted but ignored.
  - The block samples random candidates indefinitely until a free cell is found.
  - `fail` is tied to 0.

## Structure
- Package `snake_pkg` holds:
  - GRID_W, GRID_H, X_BITS, Y_BITS defaults.
  - Coordinate typedefs.
  - FSM state enum: IDLE, SAMPLE, WAIT, CHECK, SCAN_Q, SCAN_W, SCAN_C.
- Sub-module `food_cand_gen`: salt counter, XOR/split into x/y, and the in-range flag.
- The top level holds the FSM, tries counter, scan counters and output registers.

## Test plan
- Free cell, first try:
  - Stimulus: reset, then drive `rnd` so the cand at SAMPLE gives (5,7); `occupied`=0; `place_req` in cycle 0.
  - Required: `query_en` in cycle 2 with (5,7); `food_valid`=1 with `food_x`=5, `food_y`=7 in cycle 4; `busy` falls in cycle 4.
- Out-of-range rejection:
  - Stimulus: first cand x=45 (>=40), next cand (3,2) free.
  - Required: no `query_en` for (45,*); food (3,2) valid in cycle 5.
- Occupied retry:
  - Stimulus: `occupied`=1 for the first two queries, 0 for the third.
  - Required: three `query_en` pulses spaced ≥3 cycles apart; food equals the third query's coordinates.
- Fallback scan (macro defined):
  - Stimulus: `occupied`=1 everywhere except cell (2,0).
  - Required: 8 random tries, then scan queries (0,0), (1,0), (2,0); food (2,0) valid.
- Full grid (macro defined):
  - Stimulus: `occupied`=1 for all cells.
  - Required: one `fail` pulse after the (39,29) check; `food_valid`=0; `busy`=0.
- Request while busy, and reset mid-scan:
  - Stimulus: second `place_req` during WAIT; later, `reset` asserted during SCAN_W.
  - Required: the second request is ignored. After reset: next cycle `busy`=0, `query_en`=0, `food_valid`=0, `fail`=0.
